// File: rtl/cp0_timer_ctl.sv
`default_nettype none
// ====================================================================
// Module : cp0_timer_ctl
// MIPS CP0 (SR/Cause/EPC/PRId/BadVAddr) with exception/interrupt entry;
// Count/Compare timer is built only when CP0_TIMER_EN is defined.
// Rev    : 1.0
// ====================================================================
module cp0_timer_ctl #(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VAL   = 32'h12345678,
  parameter int          TIMER_LINE = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 we,
  input  logic [29:0]          pc,
  input  logic                 in_bd,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 int_req,
  output logic [29:0]          epc_out,
  output logic                 exl_out,
  output logic [31:0]          rd_data
);

  localparam logic [4:0] c_addr_badv    = 5'd8;
  localparam logic [4:0] c_addr_count   = 5'd9;
  localparam logic [4:0] c_addr_compare = 5'd11;
  localparam logic [4:0] c_addr_sr      = 5'd12;
  localparam logic [4:0] c_addr_cause   = 5'd13;
  localparam logic [4:0] c_addr_epc     = 5'd14;
  localparam logic [4:0] c_addr_prid    = 5'd15;
  localparam logic [5:0] c_im_mask      = 6'((7'd1 << NUM_HWINT) - 7'd1);

  logic [5:0]  r_im;
  logic [5:0]  r_ip;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [29:0] r_epc;
  logic [31:0] r_badv;

  logic [5:0]  w_hw_pad;
  logic [5:0]  w_ti_vec;
  logic [5:0]  w_ip_eff;
  logic        w_ti;
  logic        w_irq;
  logic        w_exc;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hw_pad
      if (gi < NUM_HWINT) begin : g_line
        assign w_hw_pad[gi] = hw_int[gi];
      end else begin : g_zero
        assign w_hw_pad[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_mtc0;

  // A write squashed by entry/ERET must not touch the timer either.
  assign w_mtc0 = we & ~int_req & ~eret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
    end else begin
      r_count <= (w_mtc0 && wr_addr == c_addr_count) ? wr_data : r_count + 32'd1;
      if (w_mtc0 && wr_addr == c_addr_compare) begin
        r_compare <= wr_data;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti         = r_ti;
  assign w_count_rd   = r_count;
  assign w_compare_rd = r_compare;
`else
  assign w_ti         = 1'b0;
  assign w_count_rd   = 32'd0;
  assign w_compare_rd = 32'd0;
`endif

  assign w_ti_vec = 6'(w_ti) << TIMER_LINE;
  assign w_ip_eff = w_hw_pad | w_ti_vec;
  // Interrupt uses live lines, not the lagging Cause.IP copy.
  assign w_irq    = (|(w_ip_eff & r_im)) & r_ie & ~r_exl;
  assign w_exc    = (exc_code != 5'd0) & ~r_exl;
  assign int_req  = w_irq | w_exc;
  assign epc_out  = r_epc;
  assign exl_out  = r_exl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_ip       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_epc      <= 30'd0;
      r_badv     <= 32'd0;
    end else begin
      r_ip <= w_ip_eff;
      if (int_req) begin
        r_exl      <= 1'b1;
        r_bd       <= in_bd;
        r_epc      <= in_bd ? pc - 30'd1 : pc;
        r_exc_code <= w_irq ? 5'd0 : exc_code;
        if (!w_irq && (exc_code == 5'd4 || exc_code == 5'd5)) begin
          r_badv <= bad_vaddr;
        end
      end else if (eret) begin
        r_exl <= 1'b0;
      end else if (we) begin
        case (wr_addr)
          c_addr_sr: begin
            r_im  <= wr_data[15:10] & c_im_mask;
            r_exl <= wr_data[1];
            r_ie  <= wr_data[0];
          end
          c_addr_epc: r_epc <= wr_data[31:2];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      c_addr_badv:    rd_data = r_badv;
      c_addr_count:   rd_data = w_count_rd;
      c_addr_compare: rd_data = w_compare_rd;
      c_addr_sr:      rd_data = {16'd0, r_im, 8'd0, r_exl, r_ie};
      c_addr_cause:   rd_data = {r_bd, w_ti, 14'd0, r_ip, 3'd0, r_exc_code, 2'd0};
      c_addr_epc:     rd_data = {r_epc, 2'b00};
      c_addr_prid:    rd_data = PRID_VAL;
      default:        rd_data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_timer_ctl.sv
`default_nettype none
// Bench for cp0_timer_ctl: directed table, random run against a reference
// model, and timer sequences when CP0_TIMER_EN is defined.
module tb_cp0_timer_ctl;
  localparam int          NHW  = 6;
  localparam logic [31:0] PRID = 32'h12345678;
  localparam int          TL   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] wr_data, bad_vaddr;
  logic        we, in_bd, eret;
  logic [29:0] pc;
  logic [NHW-1:0] hw_int;
  logic        int_req, exl_out;
  logic [29:0] epc_out;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  cp0_timer_ctl #(.NUM_HWINT(NHW), .PRID_VAL(PRID), .TIMER_LINE(TL)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .we(we), .pc(pc), .in_bd(in_bd), .exc_code(exc_code),
    .bad_vaddr(bad_vaddr), .hw_int(hw_int), .eret(eret), .int_req(int_req),
    .epc_out(epc_out), .exl_out(exl_out), .rd_data(rd_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  logic [5:0]  m_im, m_ip;
  bit          m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_count, m_compare;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_ip_eff();
    logic [5:0] v;
    v = 6'(hw_int);
`ifdef CP0_TIMER_EN
    if (m_ti) v[TL] = 1'b1;
`endif
    return v;
  endfunction

  function automatic bit m_irq();
    return ((m_ip_eff() & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic bit m_req();
    return m_irq() || (exc_code != 5'd0 && !m_exl);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      5'd12: return 32'(m_im) * 32'd1024 + 32'(m_exl) * 32'd2 + 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) + (32'(m_ti) << 30) + (32'(m_ip) << 10) + (32'(m_exc) << 2);
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit irq, req, wr_ok;
    logic [5:0] ipe;
    if (reset) begin
      m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = 0;
      m_epc = 0; m_badv = 0; m_count = 0; m_compare = 32'hFFFFFFFF;
      m_valid = 1'b1;
      return;
    end
    ipe   = m_ip_eff();
    irq   = m_irq();
    req   = m_req();
    wr_ok = we && !req && !eret;
`ifdef CP0_TIMER_EN
    if (wr_ok && wr_addr == 5'd11) m_ti = 1'b0;
    else if (m_count == m_compare) m_ti = 1'b1;
    if (wr_ok && wr_addr == 5'd11) m_compare = wr_data;
    m_count = (wr_ok && wr_addr == 5'd9) ? wr_data : m_count + 32'd1;
`endif
    m_ip = ipe;
    if (req) begin
      m_exl = 1'b1;
      m_bd  = in_bd;
      m_epc = {pc, 2'b00} - (in_bd ? 32'd4 : 32'd0);
      m_exc = irq ? 5'd0 : exc_code;
      if (!irq && (exc_code == 5'd4 || exc_code == 5'd5)) m_badv = bad_vaddr;
    end else if (eret) begin
      m_exl = 1'b0;
    end else if (wr_ok && wr_addr == 5'd12) begin
      m_im  = wr_data[15:10] & 6'((1 << NHW) - 1);
      m_exl = wr_data[1];
      m_ie  = wr_data[0];
    end else if (wr_ok && wr_addr == 5'd14) begin
      m_epc = wr_data & 32'hFFFFFFFC;
    end
  endtask

  task automatic check_model();
    if (!m_valid || reset) return;
    cmp("int_req", 32'(int_req), 32'(m_req()));
    cmp("exl_out", 32'(exl_out), 32'(m_exl));
    cmp("epc_out", 32'(epc_out), m_epc >> 2);
    cmp($sformatf("rd_data[%0d]", rd_addr), rd_data, m_read(rd_addr));
  endtask

  task automatic idle();
    reset = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; we = 0; pc = 0;
    in_bd = 0; exc_code = 0; bad_vaddr = 0; hw_int = 0; eret = 0;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst; logic [4:0] rd; bit w; logic [4:0] wa; logic [31:0] wd;
    logic [29:0] pc; bit bd; logic [4:0] exc; logic [31:0] bv; logic [5:0] hw; bit er;
    bit chk; bit x_req; bit x_exl; logic [29:0] x_epc; logic [31:0] x_rd;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [4:0] rd, bit w, logic [4:0] wa, logic [31:0] wd,
                              logic [29:0] p, bit bd, logic [4:0] exc, logic [31:0] bv,
                              logic [5:0] hw, bit er, bit chk, bit xr, bit xe,
                              logic [29:0] xp, logic [31:0] xd);
    vec_t v;
    v.rst = rst; v.rd = rd; v.w = w; v.wa = wa; v.wd = wd; v.pc = p; v.bd = bd;
    v.exc = exc; v.bv = bv; v.hw = hw; v.er = er; v.chk = chk; v.x_req = xr;
    v.x_exl = xe; v.x_epc = xp; v.x_rd = xd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //         rst rd w  wa  wd            pc       bd exc bv            hw         er chk rq ex epc       rd
    tbl.push_back(mk(1, 12, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 0, 0, 0, 0,        0));
    tbl.push_back(mk(0, 12, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        0));
    tbl.push_back(mk(0, 13, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        0));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        0));
    tbl.push_back(mk(0, 15, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        PRID));
    tbl.push_back(mk(0, 12, 1, 12, 32'h0000FC01, 0,      0, 0,  0,            6'b000100, 0, 1, 0, 0, 0,        0));
    tbl.push_back(mk(0, 12, 0, 0, 0,            30'h100, 0, 0,  0,            6'b000100, 0, 1, 1, 0, 0,        32'h0000FC01));
    tbl.push_back(mk(0, 13, 0, 0, 0,            30'h100, 0, 0,  0,            6'b000100, 0, 1, 0, 1, 30'h100,  32'h00001000));
    tbl.push_back(mk(0, 12, 0, 0, 0,            30'h100, 0, 0,  0,            6'b000100, 1, 1, 0, 1, 30'h100,  32'h0000FC03));
    tbl.push_back(mk(0, 12, 0, 0, 0,            30'h100, 0, 0,  0,            6'b000100, 0, 1, 1, 0, 30'h100,  32'h0000FC01));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 1, 1, 0, 1, 30'h100,  32'h00000400));
    tbl.push_back(mk(0, 12, 0, 0, 0,            30'hC04, 1, 5,  32'h1235,     6'b000000, 0, 1, 1, 0, 30'h100,  32'h0000FC01));
    tbl.push_back(mk(0, 13, 0, 0, 0,            30'h200, 0, 5,  32'hDEAD,     6'b000000, 0, 1, 0, 1, 30'hC03,  32'h80000014));
    tbl.push_back(mk(0, 8,  0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 1, 30'hC03,  32'h00001235));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 1, 30'hC03,  32'h0000300C));
    tbl.push_back(mk(0, 13, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 1, 1, 0, 1, 30'hC03,  32'h80000014));
    tbl.push_back(mk(0, 12, 1, 14, 32'hAAAA0000, 30'h50, 0, 10, 32'h7777,     6'b000001, 0, 1, 1, 0, 30'hC03,  32'h0000FC01));
    tbl.push_back(mk(0, 13, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 1, 30'h50,   32'h00000400));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 1, 30'h50,   32'h00000140));
    tbl.push_back(mk(0, 8,  0, 0, 0,            0,       0, 0,  0,            6'b000000, 1, 1, 0, 1, 30'h50,   32'h00001235));
    tbl.push_back(mk(0, 14, 1, 14, 32'h0000ABCF, 0,      0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h50,   32'h00000140));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h2AF3, 32'h0000ABCC));
    tbl.push_back(mk(0, 15, 1, 13, 32'hFFFFFFFF, 0,      0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h2AF3, PRID));
    tbl.push_back(mk(0, 13, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h2AF3, 32'h00000000));
    tbl.push_back(mk(0, 3,  1, 15, 32'h00000000, 0,      0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h2AF3, 32'h00000000));
    tbl.push_back(mk(0, 15, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 30'h2AF3, PRID));
    tbl.push_back(mk(1, 12, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 0, 0, 0, 0,        0));
    tbl.push_back(mk(0, 12, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        0));
    tbl.push_back(mk(0, 14, 0, 0, 0,            0,       0, 0,  0,            6'b000000, 0, 1, 0, 0, 0,        0));

    idle();
    foreach (tbl[i]) begin
      reset = tbl[i].rst; rd_addr = tbl[i].rd; we = tbl[i].w; wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd; pc = tbl[i].pc; in_bd = tbl[i].bd; exc_code = tbl[i].exc;
      bad_vaddr = tbl[i].bv; hw_int = tbl[i].hw; eret = tbl[i].er;
      settle();
      if (tbl[i].chk) begin
        cmp($sformatf("tbl%0d int_req", i), 32'(int_req), 32'(tbl[i].x_req));
        cmp($sformatf("tbl%0d exl_out", i), 32'(exl_out), 32'(tbl[i].x_exl));
        cmp($sformatf("tbl%0d epc_out", i), 32'(epc_out), 32'(tbl[i].x_epc));
        cmp($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].x_rd);
      end
      tick();
    end

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] addrs [8];
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
      idle();
      reset     = ($urandom_range(0, 299) == 0);
      rd_addr   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
      we        = ($urandom_range(0, 3) == 0);
      wr_addr   = addrs[$urandom_range(0, 7)];
      wr_data   = $urandom;
      if (wr_addr == 5'd12 && $urandom_range(0, 1) == 1) wr_data[1] = 1'b0;
      if (wr_addr == 5'd9 && $urandom_range(0, 1) == 1) wr_data = m_compare - 32'($urandom_range(0, 3));
      pc        = 30'($urandom);
      in_bd     = 1'($urandom);
      exc_code  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      if (exc_code != 0 && $urandom_range(0, 1) == 1) exc_code = 5'($urandom_range(4, 5));
      bad_vaddr = $urandom;
      hw_int    = ($urandom_range(0, 3) == 0) ? NHW'($urandom) : '0;
      eret      = ($urandom_range(0, 7) == 0);
      settle();
      check_model();
      tick();
    end

    // Timer corner sequences
    idle(); reset = 1; settle(); tick();
    idle(); we = 1; wr_addr = 12; wr_data = 32'h00008001; settle(); check_model(); tick();
`ifdef CP0_TIMER_EN
    idle(); we = 1; wr_addr = 9; wr_data = 0; settle(); check_model(); tick();
    idle(); we = 1; wr_addr = 11; wr_data = 5; rd_addr = 9; settle();
    cmp("count after load", rd_data, 32'd0); check_model(); tick();
    for (int k = 1; k <= 5; k++) begin
      idle(); rd_addr = 9; settle();
      cmp($sformatf("count %0d", k), rd_data, 32'(k));
      cmp($sformatf("no tirq at count %0d", k), 32'(int_req), 32'd0);
      check_model(); tick();
    end
    idle(); rd_addr = 13; settle();
    cmp("timer int_req", 32'(int_req), 32'd1);
    cmp("cause TI set", 32'(rd_data[30]), 32'd1);
    check_model(); tick();
    idle(); we = 1; wr_addr = 11; wr_data = 100; settle(); check_model(); tick();
    idle(); rd_addr = 13; settle();
    cmp("cause TI cleared", 32'(rd_data[30]), 32'd0); check_model(); tick();
    idle(); we = 1; wr_addr = 9; wr_data = 32'hFFFFFFFE; settle(); check_model(); tick();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_c [3];
      exp_c = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
      idle(); rd_addr = 9; settle();
      cmp($sformatf("count wrap %0d", k), rd_data, exp_c[k]); check_model(); tick();
    end
    idle(); reset = 1; settle(); tick();
    idle(); rd_addr = 9; settle(); cmp("count after reset", rd_data, 32'd0); check_model(); tick();
    idle(); rd_addr = 11; settle(); cmp("compare after reset", rd_data, 32'hFFFFFFFF); check_model(); tick();
    idle(); rd_addr = 13; settle(); cmp("TI after reset", 32'(rd_data[30]), 32'd0); check_model(); tick();
`else
    idle(); we = 1; wr_addr = 9; wr_data = 32'h1234; settle(); check_model(); tick();
    idle(); we = 1; wr_addr = 11; wr_data = 32'h5; rd_addr = 9; settle();
    cmp("count absent", rd_data, 32'd0); check_model(); tick();
    for (int k = 0; k < 8; k++) begin
      idle(); rd_addr = 13; settle();
      cmp("no timer irq", 32'(int_req), 32'd0);
      cmp("cause TI zero", 32'(rd_data[30]), 32'd0);
      check_model(); tick();
    end
    idle(); rd_addr = 11; settle(); cmp("compare absent", rd_data, 32'd0); check_model(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp0_timer_ctl.md
Name: cp0_timer_ctl

Overview:
Parametrised system-control coprocessor (CP0) for the pipelined MIPS core. Holds SR, Cause, EPC, PRId, BadVAddr and a Count/Compare timer, and evaluates interrupt/exception requests each cycle. Sits beside the M/W stage: MFC0/MTC0 access it, it drives int_req to flush the pipeline, and it supplies epc_out to NPC. Adds configurable interrupt-line count, timer interrupt, BadVAddr capture and defined priority between entry/ERET/MTC0.

Parameters:
NUM_HWINT, 6, external interrupt lines (1..6); they map to IP[2+NUM_HWINT-1:2] and IM[10+NUM_HWINT-1:10]; upper IP/IM bits read 0.
PRID_VAL, 32'h12345678, constant returned for PRId.
TIMER_LINE, 5, IP/IM bit index (0..5, counted from IP2) that the timer pending flag ORs into.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
rd_addr  in  5  MFC0 register number.
wr_addr  in  5  MTC0 register number.
wr_data  in  32  MTC0 write data.
we  in  1  MTC0 write enable.
pc  in  30  PC[31:2] of the faulting/interrupted instruction.
in_bd  in  1  instruction is in a branch delay slot.
exc_code  in  5  ExcCode[6:2]; 0 = no exception.
bad_vaddr  in  32  faulting address, valid with exc_code 4/5.
hw_int  in  NUM_HWINT  level-sensitive device interrupts.
eret  in  1  ERET executing; clears EXL.
int_req  out  1  take interrupt/exception this cycle (combinational).
epc_out  out  30  EPC[31:2].
exl_out  out  1  SR.EXL.
rd_data  out  32  MFC0 read data (combinational).

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId; other addresses read 0, writes ignored.
- SR = {16'b0, IM[15:10], 8'b0, EXL, IE}. Cause = {BD, TI, 14'b0, IP[7:2], 3'b0, ExcCode[6:2], 2'b0}. EPC stored word-aligned (bits 1:0 = 0).
- Reset: IM=0, EXL=0, IE=0, BD=0, TI=0, IP=0, ExcCode=0, EPC=0, BadVAddr=0, Count=0, Compare=32'hFFFFFFFF. Outputs after reset: int_req=0, epc_out=0, exl_out=0.
- ip_eff = {hw_int, zero-padded} | (TI << TIMER_LINE). IP register <= ip_eff every non-reset cycle (one-cycle visibility lag in Cause).
- irq = |(ip_eff & IM) & IE & !EXL (uses live ip_eff, not registered IP). exc = (exc_code != 0) & !EXL. int_req = irq | exc.
- Per-cycle priority (non-reset): 1) entry if int_req; 2) else eret; 3) else MTC0 write if we. MTC0 coinciding with entry or eret is dropped (instruction squashed).
- Entry: EXL<=1; BD<=in_bd; EPC<= in_bd ? {pc,2'b00}-4 : {pc,2'b00} (32-bit wrap); ExcCode<= irq ? 0 : exc_code (interrupt wins). BadVAddr<=bad_vaddr only when !irq and exc_code is 4 or 5.
- ERET: EXL<=0; nothing else changes.
- MTC0: SR writes IM (masked to NUM_HWINT bits), EXL, IE; EPC writes {wr_data[31:2],2'b00}; Count writes Count; Compare writes Compare and clears TI; Cause/PRId/BadVAddr read-only.
- Timer: Count increments by 1 each cycle, 32'hFFFFFFFF wraps to 0; MTC0 to Count loads wr_data instead of incrementing that cycle. If Count == Compare in a cycle, TI<=1 at the next edge (sticky) unless the same cycle writes Compare (clear wins). Timer runs regardless of EXL.
- rd_data reflects current register state; same-cycle MTC0 not forwarded.

Optional Feature:
CP0_TIMER_EN: defined -> Count, Compare, TI implemented as above. Undefined -> no Count/Compare storage, addresses 9/11 read 0 and ignore writes, Cause.TI reads 0, TI never contributes to ip_eff; TIMER_LINE unused.

Test Plan:
- Reset, read 12/13/14/15 -> 0, 0, 0, 32'h12345678; int_req=0.
- MTC0 SR=32'h0000FC01, hw_int=6'b000100 -> int_req=1 same cycle; next edge EXL=1, ExcCode=0, EPC={pc,00}; int_req falls; eret -> EXL=0, int_req=1 again.
- exc_code=5, in_bd=1, pc=30'h00000C04 (PC 0x3010), bad_vaddr=32'h1235, EXL=0 -> EPC=0x300C, BD=1, Cause.ExcCode=5, BadVAddr=0x1235; repeat with EXL=1 -> no update.
- Simultaneous hw_int interrupt and exc_code=10 -> ExcCode=0; MTC0 EPC in same cycle ignored.
- (CP0_TIMER_EN) IE=1, IM bit15 set, write Count=0 then Compare=5 -> TI=1 and int_req=1 edge after Count==5; write Compare=100 -> TI=0.
- (CP0_TIMER_EN) write Count=32'hFFFFFFFE -> reads FFFFFFFF then 0 on successive cycles; reset mid-count -> Count=0, Compare=32'hFFFFFFFF, TI=0.
